// File: rtl/logic_gates_checker.sv
// rtl/logic_gates_checker.sv - checks observed gate outputs against a/b over a run of NUM_VEC samples
module logic_gates_checker #(
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             and_gate,
    input  logic             or_gate,
    input  logic             not_gate,
    input  logic             nand_gate,
    input  logic             nor_gate,
    input  logic             xor_gate,
    input  logic             xnor_gate,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [6:0]       fail_mask,
    output logic [1:0]       first_fail_ab,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // vec_cnt value just before the acceptance that completes the run
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [6:0]       fail_mask_q, fail_mask_d;
    logic [1:0]       first_fail_ab_q, first_fail_ab_d;
    logic             first_fail_valid_q, first_fail_valid_d;

    logic [6:0] exp_vec;
    logic [6:0] obs_vec;
    logic [6:0] miss_vec;
    logic       accept;
    logic       restart;

    // Per-gate mismatch; case inequality so X/Z on an observed output counts as a miss
    always_comb begin
        exp_vec  = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        obs_vec  = {and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate};
        miss_vec = 7'd0;
        for (int i = 0; i < 7; i++) begin
            miss_vec[i] = (obs_vec[i] !== exp_vec[i]);
        end
    end

    // Samples only count while running; start is honoured only outside RUN
    always_comb begin
        accept  = (state_q == ST_RUN) && sample_valid;
        restart = start && (state_q != ST_RUN);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && (vec_cnt_q == LAST_IDX)) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result datapath: clear on (re)start, accumulate on each accepted sample
    always_comb begin
        vec_cnt_d          = vec_cnt_q;
        err_cnt_d          = err_cnt_q;
        fail_mask_d        = fail_mask_q;
        first_fail_ab_d    = first_fail_ab_q;
        first_fail_valid_d = first_fail_valid_q;
        if (restart) begin
            vec_cnt_d          = '0;
            err_cnt_d          = '0;
            fail_mask_d        = 7'd0;
            first_fail_ab_d    = 2'd0;
            first_fail_valid_d = 1'b0;
        end else if (accept) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
            if (|miss_vec) begin
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                fail_mask_d = fail_mask_q | miss_vec;
                if (!first_fail_valid_q) begin
                    first_fail_ab_d    = {a, b};
                    first_fail_valid_d = 1'b1;
                end
            end
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            vec_cnt_q          <= '0;
            err_cnt_q          <= '0;
            fail_mask_q        <= 7'd0;
            first_fail_ab_q    <= 2'd0;
            first_fail_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            vec_cnt_q          <= vec_cnt_d;
            err_cnt_q          <= err_cnt_d;
            fail_mask_q        <= fail_mask_d;
            first_fail_ab_q    <= first_fail_ab_d;
            first_fail_valid_q <= first_fail_valid_d;
        end
    end

    // Outputs decoded from state and registered results
    always_comb begin
        busy             = (state_q == ST_RUN);
        done             = (state_q == ST_DONE);
        pass             = (state_q == ST_DONE) && (err_cnt_q == '0);
        vec_cnt          = vec_cnt_q;
        err_cnt          = err_cnt_q;
        fail_mask        = fail_mask_q;
        first_fail_ab    = first_fail_ab_q;
        first_fail_valid = first_fail_valid_q;
    end

endmodule

// File: tb/tb_logic_gates_checker.sv
// tb/tb_logic_gates_checker.sv - directed self-checking bench for logic_gates_checker
module tb_logic_gates_checker;

    logic clk = 1'b0;
    logic rst, start, sample_valid, a, b;
    logic and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate;
    logic [6:0] flip_mask;
    logic [6:0] zero_mask;
    logic [6:0] gate_vec;

    logic       busy, done, pass, first_fail_valid;
    logic [7:0] vec_cnt, err_cnt;
    logic [6:0] fail_mask;
    logic [1:0] first_fail_ab;

    logic       busy2, done2, pass2, first_fail_valid2;
    logic [1:0] vec_cnt2, err_cnt2;
    logic [6:0] fail_mask2;
    logic [1:0] first_fail_ab2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate model: correct truth values, optionally inverted or stuck at 0 per gate
    assign gate_vec = ({a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)} ^ flip_mask) & ~zero_mask;
    assign {and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate} = gate_vec;

    logic_gates_checker #(.NUM_VEC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .and_gate(and_gate), .or_gate(or_gate), .not_gate(not_gate), .nand_gate(nand_gate),
        .nor_gate(nor_gate), .xor_gate(xor_gate), .xnor_gate(xnor_gate),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .fail_mask(fail_mask), .first_fail_ab(first_fail_ab), .first_fail_valid(first_fail_valid)
    );

    logic_gates_checker #(.NUM_VEC(3), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .and_gate(and_gate), .or_gate(or_gate), .not_gate(not_gate), .nand_gate(nand_gate),
        .nor_gate(nor_gate), .xor_gate(xor_gate), .xnor_gate(xnor_gate),
        .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2),
        .fail_mask(fail_mask2), .first_fail_ab(first_fail_ab2), .first_fail_valid(first_fail_valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic [1:0] ab);
        {a, b} = ab;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sample_valid = 1'b0; a = 1'b0; b = 1'b0;
        flip_mask = 7'd0; zero_mask = 7'd0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_vec", vec_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_mask", fail_mask, 0);
        check("rst_ffv", first_fail_valid, 0);

        // all gates correct
        do_start();
        check("good_busy", busy, 1);
        check("good_vec0", vec_cnt, 0);
        do_sample(2'b00); do_sample(2'b01); do_sample(2'b10);
        check("good_vec3", vec_cnt, 3);
        check("good_busy3", busy, 1);
        do_sample(2'b11);
        check("good_done", done, 1);
        check("good_busy4", busy, 0);
        check("good_vec", vec_cnt, 4);
        check("good_err", err_cnt, 0);
        check("good_pass", pass, 1);
        check("good_mask", fail_mask, 0);

        // xor stuck at 0
        zero_mask = 7'b0000010;
        do_start();
        check("xor_clear_vec", vec_cnt, 0);
        check("xor_clear_done", done, 0);
        do_sample(2'b00); do_sample(2'b01); do_sample(2'b10); do_sample(2'b11);
        check("xor_err", err_cnt, 2);
        check("xor_mask", fail_mask, 7'b0000010);
        check("xor_ffab", first_fail_ab, 2'b01);
        check("xor_ffv", first_fail_valid, 1);
        check("xor_pass", pass, 0);
        check("xor_done", done, 1);

        // results hold in DONE, sample_valid ignored
        do_sample(2'b01); do_sample(2'b10); tick();
        check("hold_vec", vec_cnt, 4);
        check("hold_err", err_cnt, 2);
        check("hold_done", done, 1);
        zero_mask = 7'd0;

        // valid gaps 1,0,1,0,...
        do_start();
        for (int i = 0; i < 7; i++) begin
            {a, b} = 2'(i >> 1);
            sample_valid = (i % 2 == 0);
            tick();
            if (i == 4) check("gap_vec3", vec_cnt, 3);
        end
        sample_valid = 1'b0;
        check("gap_vec", vec_cnt, 4);
        check("gap_done", done, 1);
        check("gap_pass", pass, 1);

        // reset mid-run after 2 failing samples
        flip_mask = 7'h7f;
        do_start();
        do_sample(2'b10); do_sample(2'b11);
        check("mid_err2", err_cnt, 2);
        check("mid_ffab", first_fail_ab, 2'b10);
        do_reset();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vec", vec_cnt, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_mask", fail_mask, 0);
        check("mid_rst_ffv", first_fail_valid, 0);
        flip_mask = 7'd0;
        do_start();
        do_sample(2'b00); do_sample(2'b01); do_sample(2'b10); do_sample(2'b11);
        check("after_rst_pass", pass, 1);

        // start in RUN ignored, start in DONE restarts and drops that cycle's sample
        do_start();
        do_sample(2'b01);
        do_start();
        check("runstart_vec", vec_cnt, 1);
        check("runstart_busy", busy, 1);
        zero_mask = 7'b1000000;
        do_sample(2'b11);
        zero_mask = 7'd0;
        do_sample(2'b00); do_sample(2'b10);
        check("rs_done", done, 1);
        check("rs_err", err_cnt, 1);
        check("rs_mask", fail_mask, 7'b1000000);
        start = 1'b1; sample_valid = 1'b1; {a, b} = 2'b11; flip_mask = 7'h7f;
        tick();
        start = 1'b0; sample_valid = 1'b0; flip_mask = 7'd0;
        check("restart_busy", busy, 1);
        check("restart_vec", vec_cnt, 0);
        check("restart_err", err_cnt, 0);
        check("restart_mask", fail_mask, 0);
        check("restart_ffv", first_fail_valid, 0);
        do_sample(2'b00); do_sample(2'b01); do_sample(2'b10); do_sample(2'b11);
        check("restart_pass", pass, 1);

        // rst beats start and sample_valid
        rst = 1'b1; start = 1'b1; sample_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; sample_valid = 1'b0;
        check("rstprio_busy", busy, 0);
        check("rstprio_vec", vec_cnt, 0);

        // small instance, every sample failing: saturation at 3
        flip_mask = 7'h7f;
        do_start();
        do_sample(2'b01); do_sample(2'b10); do_sample(2'b11);
        flip_mask = 7'd0;
        check("sat_done", done2, 1);
        check("sat_err", err_cnt2, 3);
        check("sat_vec", vec_cnt2, 3);
        check("sat_mask", fail_mask2, 7'h7f);
        check("sat_ffab", first_fail_ab2, 2'b01);
        check("sat_pass", pass2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_gates_checker.md
LOGIC_GATES_CHECKER -- requirements
Module: logic_gates_checker

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 4, meaning the number of accepted samples per run (range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the vector and error counters.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle run request.
REQ-007 sample_valid  input  1  the current a/b/gate outputs are a settled vector to check.
REQ-008 a, b  input  1 each  stimulus applied to the gate block.
REQ-009 and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate  input  1 each  observed gate outputs.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  done and err_cnt==0.
REQ-013 vec_cnt  output  CNT_W  samples accepted in the current run.
REQ-014 err_cnt  output  CNT_W  samples with at least one mismatching gate, saturating.
REQ-015 fail_mask  output  7  sticky per-gate mismatch flags; bit order [6:0] = and, or, not, nand, nor, xor, xnor.
REQ-016 first_fail_ab  output  2  {a,b} of the first failing sample in the run.
REQ-017 first_fail_valid  output  1  first_fail_ab holds a captured value.

Function
REQ-018 Expected values SHALL be and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
REQ-019 A gate mismatch SHALL be any difference under 4-state case inequality, so X or Z on an observed output counts as a mismatch.
REQ-020 FSM states SHALL be IDLE, RUN, and DONE.
REQ-021 IDLE->RUN SHALL occur on start; the same edge clears vec_cnt, err_cnt, fail_mask, first_fail_ab, and first_fail_valid.
REQ-022 In RUN, each cycle with sample_valid=1 SHALL be accepted; the check result is registered at the next rising edge (1-cycle latency).
REQ-023 On acceptance, vec_cnt SHALL increment by 1.
REQ-024 On acceptance, if any gate mismatches: err_cnt SHALL increment (holding at 2^CNT_W-1 once reached), and fail_mask SHALL OR in the per-gate mismatch bits.
REQ-025 On acceptance, if any gate mismatches and first_fail_valid=0: first_fail_ab SHALL be set to {a,b} and first_fail_valid to 1.
REQ-026 RUN->DONE SHALL occur on the edge that accepts sample number NUM_VEC (vec_cnt becomes NUM_VEC on that edge).
REQ-027 sample_valid SHALL be ignored in IDLE and DONE, and on the cycle start is taken.
REQ-028 start in RUN SHALL be ignored.
REQ-029 start in DONE SHALL clear all results and enter RUN on the same edge.
REQ-030 Results SHALL hold stable in DONE until start or rst.
REQ-031 pass SHALL be combinational from state and err_cnt; all other outputs SHALL be registered or decoded from state.

Reset
REQ-032 When rst=1 at a rising edge, the block SHALL enter IDLE and clear vec_cnt, err_cnt, fail_mask, first_fail_ab, and first_fail_valid to 0; busy, done, and pass are then 0.
REQ-033 rst SHALL take priority over start and sample_valid.
REQ-034 rst mid-RUN SHALL abort the run with no partial result retained.

Verification
REQ-035 Correct gates, start, then 4 samples ab=00,01,10,11 -> DONE after the 4th edge, vec_cnt=4, err_cnt=0, pass=1, fail_mask=0.
REQ-036 xor_gate forced to 0, same 4 vectors -> err_cnt=2, fail_mask=7'b0000010, first_fail_ab=2'b01, first_fail_valid=1, pass=0.
REQ-037 sample_valid gaps (pattern 1,0,1,0,...) -> vec_cnt counts only the valid cycles; DONE is reached after 4 accepted samples.
REQ-038 rst asserted after 2 accepted samples -> IDLE, all counters 0; a following start and 4 good samples -> pass=1.
REQ-039 start re-pulsed in RUN (ignored) and then in DONE -> the restart clears results and enters RUN; sample_valid on the start cycle is not counted.
REQ-040 CNT_W=2, NUM_VEC=3, all samples failing -> err_cnt=3 (saturation reached, no wrap), done=1.
